// File: rtl/ifetch_icache.sv
// ifetch_icache
//   Instruction fetch unit with a small direct-mapped instruction cache
//   (one 32-bit word per line). The PC is looked up every cycle. A hit loads
//   the registered decoder output. A miss is refilled through the memory
//   controller fetch port. A redirect flushes the output and restarts fetch.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes every register
//   mc_en/mc_pc     fetch request to memory controller (held until mc_done)
//   mc_done/mc_data one-cycle completion pulse with the fetched word
//   inst_valid/inst_ready/inst/inst_pc  registered decoder handshake
//   redirect/redirect_pc                flush and restart at a new PC
module ifetch_icache #(
  parameter int          IDX_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mc_en,
  output logic [31:0] mc_pc,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {LOOKUP, MISS, DRAIN} state_t;

  state_t            state;
  logic [31:0]       pc;
  logic [LINES-1:0]  line_vld;
  logic [TAG_W-1:0]  tag_ram  [LINES];
  logic [31:0]       data_ram [LINES];

  logic [IDX_W-1:0]  pc_idx, mc_idx;
  logic [TAG_W-1:0]  pc_tag, mc_tag;
  logic              hit, out_free, fill;
  logic [31:0]       redir_pc_al;

  assign pc_idx      = pc[IDX_W+1:2];
  assign pc_tag      = pc[31:IDX_W+2];
  assign mc_idx      = mc_pc[IDX_W+1:2];
  assign mc_tag      = mc_pc[31:IDX_W+2];
  assign hit         = line_vld[pc_idx] && (tag_ram[pc_idx] == pc_tag);
  assign out_free    = !inst_valid || inst_ready;
  assign redir_pc_al = {redirect_pc[31:2], 2'b00};
  // mc_done is only meaningful while a request is outstanding; mc_pc still
  // names the requested address, even after a redirect moved pc elsewhere.
  assign fill        = rdy && mc_done && (state != LOOKUP);

  // Tag/data storage needs no reset; line_vld gates every use.
  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      tag_ram[mc_idx]  <= mc_tag;
      data_ram[mc_idx] <= mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOOKUP;
      pc         <= RESET_PC;
      line_vld   <= '0;
      mc_en      <= 1'b0;
      mc_pc      <= 32'h0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
    end else if (rdy) begin
      case (state)
        LOOKUP: begin
          if (redirect) begin
            // Wins over inst_ready: the held instruction is dropped.
            pc         <= redir_pc_al;
            inst_valid <= 1'b0;
          end else if (hit) begin
            if (out_free) begin
              inst       <= data_ram[pc_idx];
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + 32'd4;
            end
          end else begin
            // Miss starts immediately; a held instruction may still drain.
            state <= MISS;
            mc_en <= 1'b1;
            mc_pc <= pc;
            if (inst_ready) inst_valid <= 1'b0;
          end
        end
        MISS: begin
          if (inst_ready) inst_valid <= 1'b0;
          if (mc_done) begin
            line_vld[mc_idx] <= 1'b1;
            mc_en            <= 1'b0;
            state            <= LOOKUP;
            if (redirect) begin
              pc         <= redir_pc_al;
              inst_valid <= 1'b0;
            end
          end else if (redirect) begin
            // Controller cannot abort: keep mc_en up and discard the result.
            pc         <= redir_pc_al;
            inst_valid <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect) pc <= redir_pc_al;
          if (mc_done) begin
            line_vld[mc_idx] <= 1'b1;
            mc_en            <= 1'b0;
            state            <= LOOKUP;
          end
        end
        default: state <= LOOKUP;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_icache.sv
// Directed bench for ifetch_icache: a vector table for cold start, miss,
// backpressure, redirect and freeze cases, followed by hand-written
// sequences for the 16-line hit stream and redirect during drain.
module tb_ifetch_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, mc_en, mc_done, inst_valid, inst_ready, redirect;
  logic [31:0] mc_pc, mc_data, inst, inst_pc, redirect_pc;

  int n_chk = 0;
  int n_fail = 0;

  ifetch_icache #(.IDX_W(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mc_en(mc_en), .mc_pc(mc_pc), .mc_done(mc_done), .mc_data(mc_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, red;
    logic [31:0] rpc;
    logic        ird, done;
    logic [31:0] data;
    logic        en;
    logic [31:0] mpc;
    logic        iv;
    logic [31:0] inst, ipc;
  } vec_t;

  vec_t vq[$];
  logic [31:0] exp_mem [16];

  task automatic add(input logic r, input logic red, input logic [31:0] rpc,
                     input logic ird, input logic done, input logic [31:0] data,
                     input logic en, input logic [31:0] mpc, input logic iv,
                     input logic [31:0] ins, input logic [31:0] ipc);
    vec_t v;
    v.rdy = r; v.red = red; v.rpc = rpc; v.ird = ird; v.done = done;
    v.data = data; v.en = en; v.mpc = mpc; v.iv = iv; v.inst = ins; v.ipc = ipc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic red, input logic [31:0] rpc,
                       input logic ird, input logic done, input logic [31:0] data);
    rdy = r; redirect = red; redirect_pc = rpc; inst_ready = ird;
    mc_done = done; mc_data = data;
  endtask

  function automatic logic [31:0] fill_word(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst.mc_en", {31'b0, mc_en}, 32'h0);
    chk("rst.mc_pc", mc_pc, 32'h0);
    chk("rst.inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst.inst", inst, 32'h0);
    chk("rst.inst_pc", inst_pc, 32'h0);
    rst = 1'b0;

    //   rdy red rpc  ird done data          | en mpc  iv inst          ipc
    // cold start: miss at 0, answered on the 5th cycle
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 1, 0, 0,                  1, 0,    0, 0,            0);
    add(1, 0, 0, 1, 1, 32'h13,               0, 0,    0, 0,            0);
    add(1, 0, 0, 1, 0, 0,                    0, 0,    1, 32'h13,       0);
    add(1, 0, 0, 1, 0, 0,                    1, 4,    0, 32'h13,       0);
    add(1, 0, 0, 1, 1, 32'h1000_0004,        0, 4,    0, 32'h13,       0);
    add(1, 0, 0, 0, 0, 0,                    0, 4,    1, 32'h1000_0004, 4);
    // miss while holding an instruction; stray mc_done under rdy=0 ignored
    add(1, 0, 0, 0, 0, 0,                    1, 8,    1, 32'h1000_0004, 4);
    add(0, 0, 0, 1, 1, 32'hBAD0_BAD0,        1, 8,    1, 32'h1000_0004, 4);
    add(1, 0, 0, 1, 0, 0,                    1, 8,    0, 32'h1000_0004, 4);
    add(1, 0, 0, 1, 1, 32'h1000_0008,        0, 8,    0, 32'h1000_0004, 4);
    add(1, 0, 0, 1, 0, 0,                    0, 8,    1, 32'h1000_0008, 8);
    // redirect with inst_ready drops the held instruction
    add(1, 1, 0, 1, 0, 0,                    0, 8,    0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 0, 0,                    0, 8,    1, 32'h13,       0);
    add(1, 0, 0, 1, 0, 0,                    0, 8,    1, 32'h1000_0004, 4);
    // backpressure for 3 cycles
    for (int i = 0; i < 3; i++)
      add(1, 0, 0, 0, 0, 0,                  0, 8,    1, 32'h1000_0004, 4);
    add(1, 0, 0, 1, 0, 0,                    0, 8,    1, 32'h1000_0008, 8);
    // redirect to 0x103 (aligned to 0x100), miss, redirect mid-miss to 0x8
    add(1, 1, 32'h103, 1, 0, 0,              0, 8,    0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 0, 0,                    1, 32'h100, 0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 0, 0,                    1, 32'h100, 0, 32'h1000_0008, 8);
    add(1, 1, 8, 1, 0, 0,                    1, 32'h100, 0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 0, 0,                    1, 32'h100, 0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 1, 32'hDEAD_0100,        0, 32'h100, 0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 0, 0,                    0, 32'h100, 1, 32'h1000_0008, 8);
    // line 0 now holds 0x100: refetching 0 misses; done+redirect together
    add(1, 1, 0, 1, 0, 0,                    0, 32'h100, 0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 0, 0,                    1, 0,    0, 32'h1000_0008, 8);
    add(1, 1, 32'h40, 1, 1, 32'h13,          0, 0,    0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 0, 0,                    1, 32'h40, 0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 1, 32'h4040_4040,        0, 32'h40, 0, 32'h1000_0008, 8);
    add(1, 0, 0, 1, 0, 0,                    0, 32'h40, 1, 32'h4040_4040, 32'h40);
    // 0x40 replaced line 0, so 0x0 misses again; freeze 4 cycles in MISS
    add(1, 1, 0, 1, 0, 0,                    0, 32'h40, 0, 32'h4040_4040, 32'h40);
    add(1, 0, 0, 1, 0, 0,                    1, 0,    0, 32'h4040_4040, 32'h40);
    for (int i = 0; i < 4; i++)
      add(0, 1, 32'h80, 1, 1, 32'hBAD0_BAD0, 1, 0,    0, 32'h4040_4040, 32'h40);
    add(1, 0, 0, 1, 1, 32'h13,               0, 0,    0, 32'h4040_4040, 32'h40);
    add(1, 0, 0, 1, 0, 0,                    0, 0,    1, 32'h13,       0);

    foreach (vq[k]) begin
      drive(vq[k].rdy, vq[k].red, vq[k].rpc, vq[k].ird, vq[k].done, vq[k].data);
      step();
      chk($sformatf("v%0d.mc_en", k), {31'b0, mc_en}, {31'b0, vq[k].en});
      chk($sformatf("v%0d.mc_pc", k), mc_pc, vq[k].mpc);
      chk($sformatf("v%0d.inst_valid", k), {31'b0, inst_valid}, {31'b0, vq[k].iv});
      if (vq[k].iv) begin
        chk($sformatf("v%0d.inst", k), inst, vq[k].inst);
        chk($sformatf("v%0d.inst_pc", k), inst_pc, vq[k].ipc);
      end
    end

    // Preload lines 0x0..0x3C. Lines 0..2 already hold tag-0 words.
    exp_mem[0] = 32'h13;
    exp_mem[1] = 32'h1000_0004;
    exp_mem[2] = 32'h1000_0008;
    for (int i = 3; i < 16; i++) exp_mem[i] = 32'hX;
    begin
      bit reached = 0;
      drive(1, 1, 0, 1, 0, 0);
      for (int c = 0; c < 400 && !reached; c++) begin
        step();
        if (inst_valid && inst_pc == 32'h3C) reached = 1;
        else begin
          redirect = 1'b0;
          mc_done  = mc_en;
          mc_data  = fill_word(mc_pc);
          if (mc_en && mc_pc[31:6] == 26'h0) exp_mem[mc_pc[5:2]] = fill_word(mc_pc);
        end
      end
      chk("preload.reached_3c", {31'b0, reached}, 32'h1);
    end

    // Hit stream: 16 back-to-back hits with a 4-cycle freeze in the middle.
    drive(1, 1, 0, 1, 0, 0);
    step();
    chk("stream.redir_iv", {31'b0, inst_valid}, 32'h0);
    redirect = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("stream%0d.iv", i), {31'b0, inst_valid}, 32'h1);
      chk($sformatf("stream%0d.inst_pc", i), inst_pc, 32'(i * 4));
      chk($sformatf("stream%0d.inst", i), inst, exp_mem[i]);
      chk($sformatf("stream%0d.mc_en", i), {31'b0, mc_en}, 32'h0);
      if (i == 5) begin
        rdy = 1'b0;
        for (int f = 0; f < 4; f++) begin
          step();
          chk($sformatf("freeze%0d.iv", f), {31'b0, inst_valid}, 32'h1);
          chk($sformatf("freeze%0d.inst_pc", f), inst_pc, 32'h14);
          chk($sformatf("freeze%0d.inst", f), inst, exp_mem[5]);
        end
        rdy = 1'b1;
      end
    end

    // Redirects in DRAIN only move pc; the drained word is never delivered.
    drive(1, 1, 32'h200, 1, 0, 0);
    step();
    chk("drain.redir_iv", {31'b0, inst_valid}, 32'h0);
    drive(1, 0, 0, 1, 0, 0);
    step();
    chk("drain.miss_en", {31'b0, mc_en}, 32'h1);
    chk("drain.miss_pc", mc_pc, 32'h200);
    drive(1, 1, 32'h300, 1, 0, 0);
    step();
    chk("drain.en_held", {31'b0, mc_en}, 32'h1);
    drive(1, 1, 32'h4, 1, 0, 0);
    step();
    chk("drain.en_held2", {31'b0, mc_en}, 32'h1);
    chk("drain.pc_stable", mc_pc, 32'h200);
    drive(1, 0, 0, 1, 1, 32'h2222_2222);
    step();
    chk("drain.done_en", {31'b0, mc_en}, 32'h0);
    chk("drain.done_iv", {31'b0, inst_valid}, 32'h0);
    drive(1, 0, 0, 1, 0, 0);
    step();
    chk("drain.hit_iv", {31'b0, inst_valid}, 32'h1);
    chk("drain.hit_pc", inst_pc, 32'h4);
    chk("drain.hit_inst", inst, 32'h1000_0004);
    step();
    chk("drain.next_pc", inst_pc, 32'h8);
    chk("drain.next_inst", inst, 32'h1000_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
